// File: rtl/entrada_digito.sv
// Digit-entry front end for the BCD display decoder: synchronises switches and confirm button,
// debounces the button, latches the switch value per press and pulses ready afterwards.
module entrada_digito #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int READY_CYCLES    = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       ready,
    output logic       invalid,
    output logic [3:0] entry_count
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        CAPTURE,
        HOLD,
        WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDY_LAST = CNT_W'(READY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sw_meta_q, sw_meta_d;
    logic [3:0]       sw_s_q, sw_s_d;
    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic [3:0]       digit_q, digit_d;
    logic             invalid_q, invalid_d;
    logic             ready_q, ready_d;
    logic [3:0]       entry_count_q, entry_count_d;

    always_comb begin
        sw_meta_d     = sw;
        sw_s_d        = sw_meta_q;
        btn_meta_d    = btn;
        btn_s_d       = btn_meta_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        digit_d       = digit_q;
        invalid_d     = invalid_q;
        entry_count_d = entry_count_q;

        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAPTURE: begin
                // Out-of-range digits are still shown so the decoder can flag them, but not counted.
                digit_d   = sw_s_q;
                invalid_d = (sw_s_q >= 4'd10);
                if (sw_s_q < 4'd10) begin
                    entry_count_d = entry_count_q + 4'd1;
                end
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == RDY_LAST) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_REL: begin
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == HOLD);
    end

    // Coming out of reset in WAIT_REL forces a debounced release before the first capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_REL;
            cnt_q         <= '0;
            sw_meta_q     <= '0;
            sw_s_q        <= '0;
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            digit_q       <= '0;
            invalid_q     <= 1'b0;
            ready_q       <= 1'b0;
            entry_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sw_meta_q     <= sw_meta_d;
            sw_s_q        <= sw_s_d;
            btn_meta_q    <= btn_meta_d;
            btn_s_q       <= btn_s_d;
            digit_q       <= digit_d;
            invalid_q     <= invalid_d;
            ready_q       <= ready_d;
            entry_count_q <= entry_count_d;
        end
    end

    assign {A, B, C, D} = digit_q;
    assign invalid      = invalid_q;
    assign ready        = ready_q;
    assign entry_count  = entry_count_q;

endmodule

// File: tb/tb_entrada_digito.sv
// Self-checking bench for entrada_digito: directed scenarios plus randomized button/switch
// activity, all compared every cycle against a run-length based reference model.
module tb_entrada_digito;

    localparam int DEB = 4;
    localparam int RDY = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw    = 4'd0;
    logic       btn   = 1'b0;
    logic       A, B, C, D, ready, invalid;
    logic [3:0] entry_count;

    int vec_count  = 0;
    int miss_count = 0;

    entrada_digito #(
        .DEBOUNCE_CYCLES(DEB),
        .READY_CYCLES   (RDY),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .btn        (btn),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .ready      (ready),
        .invalid    (invalid),
        .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    // Reference model: phases tracked by run lengths of the two-cycle-delayed button.
    typedef enum {PH_RELEASE, PH_ARMED, PH_CAPTURE, PH_HOLD} phase_t;
    phase_t     m_phase = PH_RELEASE;
    int         m_run   = 0;
    int         m_hold  = 0;
    logic [3:0] m_sw_d1 = 4'd0, m_sw_d2 = 4'd0;
    logic       m_b_d1  = 1'b0, m_b_d2  = 1'b0;
    logic [3:0] m_digit = 4'd0;
    logic       m_inv   = 1'b0;
    logic       m_ready = 1'b0;
    logic [3:0] m_count = 4'd0;

    always @(posedge clk) begin : model
        logic [3:0] sw_sync;
        logic       b_sync;
        if (!reset) begin
            sw_sync = m_sw_d2;
            b_sync  = m_b_d2;
            m_sw_d2 = m_sw_d1;
            m_sw_d1 = sw;
            m_b_d2  = m_b_d1;
            m_b_d1  = btn;
            case (m_phase)
                PH_RELEASE: begin
                    m_run = b_sync ? 0 : m_run + 1;
                    if (m_run == DEB) begin
                        m_phase = PH_ARMED;
                        m_run   = 0;
                    end
                end
                PH_ARMED: begin
                    m_run = b_sync ? m_run + 1 : 0;
                    if (m_run == DEB + 1) m_phase = PH_CAPTURE;
                end
                PH_CAPTURE: begin
                    m_digit = sw_sync;
                    m_inv   = (sw_sync > 4'd9);
                    if (!m_inv) m_count = m_count + 4'd1;
                    m_ready = 1'b1;
                    m_hold  = RDY;
                    m_phase = PH_HOLD;
                end
                PH_HOLD: begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) begin
                        m_ready = 1'b0;
                        m_phase = PH_RELEASE;
                        m_run   = 0;
                    end
                end
                default: m_phase = PH_RELEASE;
            endcase
        end
    end

    function automatic logic [9:0] dutVec();
        return {A, B, C, D, invalid, ready, entry_count};
    endfunction

    function automatic logic [9:0] modelVec();
        return {m_digit, m_inv, m_ready, m_count};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clearModel();
        m_phase = PH_RELEASE;
        m_run   = 0;
        m_hold  = 0;
        m_sw_d1 = 4'd0;
        m_sw_d2 = 4'd0;
        m_b_d1  = 1'b0;
        m_b_d2  = 1'b0;
        m_digit = 4'd0;
        m_inv   = 1'b0;
        m_ready = 1'b0;
        m_count = 4'd0;
    endtask

    // Asserts reset between edges so the clear must happen without a clock.
    task automatic doReset();
        #2;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("reset_async", 32'(dutVec()), 32'(modelVec()));
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic b);
        sw  = s;
        btn = b;
        @(posedge clk);
        #1;
        checkOutput("cycle", 32'(dutVec()), 32'(modelVec()));
        @(negedge clk);
    endtask

    task automatic pressDigit(input logic [3:0] s, input bit scramble);
        repeat (8) applyStimulus(s, 1'b1);
        repeat (16) applyStimulus(scramble ? 4'($urandom) : s, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: run exceeded time budget, %0d vectors so far", vec_count);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        int         first_rise, hi_cycles, rises;
        logic       prev_ready, ready_seen;
        logic [3:0] s;
        int         hi, lo;

        doReset();
        checkOutput("reset_state", 32'(dutVec()), 32'(0));

        // Clean press held for 20 cycles: one capture, ready 8 cycles from edge DEB+4.
        repeat (6) applyStimulus(4'b0111, 1'b0);
        first_rise = 0;
        hi_cycles  = 0;
        rises      = 0;
        prev_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(4'b0111, 1'b1);
            if (ready && !prev_ready) begin
                rises++;
                if (first_rise == 0) first_rise = i;
            end
            if (ready) hi_cycles++;
            prev_ready = ready;
        end
        checkOutput("latency", 32'(first_rise), 32'(DEB + 4));
        checkOutput("ready_len", 32'(hi_cycles), 32'(RDY));
        checkOutput("one_capture", 32'(rises), 32'(1));
        checkOutput("digit_0111", 32'({A, B, C, D}), 32'(4'b0111));
        checkOutput("invalid_0111", 32'(invalid), 32'(0));
        checkOutput("count_1", 32'(entry_count), 32'(1));

        // Three synced cycles of button then release: rejected as bounce.
        repeat (8) applyStimulus(4'b0111, 1'b0);
        ready_seen = 1'b0;
        repeat (3) begin
            applyStimulus(4'b0010, 1'b1);
            ready_seen |= ready;
        end
        repeat (10) begin
            applyStimulus(4'b0010, 1'b0);
            ready_seen |= ready;
        end
        checkOutput("bounce_ready", 32'(ready_seen), 32'(0));
        checkOutput("bounce_digit", 32'({A, B, C, D}), 32'(4'b0111));

        // Out-of-range digit is shown and flagged but not counted.
        pressDigit(4'b1100, 1'b0);
        checkOutput("digit_1100", 32'({A, B, C, D}), 32'(4'b1100));
        checkOutput("invalid_1100", 32'(invalid), 32'(1));
        checkOutput("count_still_1", 32'(entry_count), 32'(1));

        // Button held across reset release must not capture.
        applyStimulus(4'b1001, 1'b1);
        doReset();
        ready_seen = 1'b0;
        repeat (20) begin
            applyStimulus(4'b1001, 1'b1);
            ready_seen |= ready;
        end
        checkOutput("held_reset_nocap", 32'(ready_seen), 32'(0));
        checkOutput("held_reset_count", 32'(entry_count), 32'(0));
        repeat (8) applyStimulus(4'b1001, 1'b0);
        pressDigit(4'b0011, 1'b0);
        checkOutput("digit_0011", 32'({A, B, C, D}), 32'(4'b0011));
        checkOutput("count_after_held", 32'(entry_count), 32'(1));

        // Reset landing in the middle of the ready pulse.
        repeat (10) applyStimulus(4'b0110, 1'b1);
        checkOutput("mid_hold_ready", 32'(ready), 32'(1));
        doReset();
        checkOutput("mid_hold_cleared", 32'(dutVec()), 32'(0));

        // Sixteen valid presses wrap the counter; switch noise during HOLD is ignored.
        repeat (8) applyStimulus(4'b0101, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            pressDigit(4'b0101, 1'b1);
            if (k == 15) checkOutput("count_15", 32'(entry_count), 32'(15));
        end
        checkOutput("count_wrap", 32'(entry_count), 32'(0));
        checkOutput("digit_0101", 32'({A, B, C, D}), 32'(4'b0101));
        checkOutput("invalid_0101", 32'(invalid), 32'(0));

        // Randomized bursts of button activity with occasional resets.
        for (int n = 0; n < 250; n++) begin
            s  = 4'($urandom);
            hi = $urandom_range(8, 1);
            lo = $urandom_range(14, 1);
            if ($urandom_range(39, 0) == 0) doReset();
            for (int i = 0; i < hi; i++) begin
                applyStimulus(($urandom_range(3, 0) == 0) ? 4'($urandom) : s, 1'b1);
            end
            for (int i = 0; i < lo; i++) begin
                applyStimulus(4'($urandom), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
